// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA line-prefetch scheduler.
// Holds the fetch FSM state enum, the two supported line lengths and the
// default burst length, plus a helper that maps the mode bit to a word count.
package vga_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } fetch_state_t;

   localparam int LINE_WORDS_640    = 640;
   localparam int LINE_WORDS_1024   = 1024;
   localparam int BURST_LEN_DEFAULT = 16;

   // Words per scan line for the selected mode (11 bits so 1024 fits).
   function automatic logic [10:0] line_words(input logic mode_wide);
      return mode_wide ? 11'(LINE_WORDS_1024) : 11'(LINE_WORDS_640);
   endfunction

endpackage

// File: rtl/vga_lb_writer.sv
// Registered write port into the A/B ping-pong line buffer.
// Latency: one cycle from wr_en to lb_we_a/lb_we_b; no backpressure (the line buffer always accepts).
// Ports: wr_en/wr_buf/wr_addr/wr_data from the fetch FSM; lb_we_a, lb_we_b, lb_waddr, lb_wdata to the buffer.
module vga_lb_writer (
   input  logic        vga_clk,
   input  logic        rst_n_w,
   input  logic        wr_en,
   input  logic        wr_buf,
   input  logic [9:0]  wr_addr,
   input  logic [15:0] wr_data,
   output logic        lb_we_a,
   output logic        lb_we_b,
   output logic [9:0]  lb_waddr,
   output logic [15:0] lb_wdata
);

   always_ff @(posedge vga_clk or negedge rst_n_w) begin
      if (!rst_n_w) begin
         lb_we_a  <= 1'b0;
         lb_we_b  <= 1'b0;
         lb_waddr <= '0;
         lb_wdata <= '0;
      end else begin
         // Exactly one strobe per write, chosen by the latched buffer bit.
         lb_we_a <= wr_en & ~wr_buf;
         lb_we_b <= wr_en &  wr_buf;
         if (wr_en) begin
            lb_waddr <= wr_addr;
            lb_wdata <= wr_data;
         end
      end
   end

endmodule

// File: rtl/vga_line_fetch_ctrl.sv
// Line-prefetch scheduler: on a line-request edge, fetches the scan line from frame memory in bursts into the idle line-buffer half.
// Latency: request edge at t gives mem_req at t+1; each read beat reaches the line buffer one cycle later.
// Backpressure: mem_req is held with a stable address until mem_gnt; a request arriving mid-fetch sets sticky overrun and restarts after the current burst.
// Ports: vga_mode/read_line_req/read_line_addr/blanking from the timing driver; mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata burst port;
//        lb_we_a/lb_we_b/lb_waddr/lb_wdata line-buffer write; busy/line_done/overrun/clr_overrun status.
module vga_line_fetch_ctrl
   import vga_pkg::*;
#(
   parameter int BURST_LEN = BURST_LEN_DEFAULT,
   parameter int ADDR_W    = 22
) (
   input  logic              vga_clk,
   input  logic              rst_n_w,
   input  logic [1:0]        vga_mode,
   input  logic              read_line_req,
   input  logic [15:0]       read_line_addr,
   input  logic              blanking,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [15:0]       mem_rdata,
   output logic              lb_we_a,
   output logic              lb_we_b,
   output logic [9:0]        lb_waddr,
   output logic [15:0]       lb_wdata,
   output logic              busy,
   output logic              line_done,
   output logic              overrun,
   input  logic              clr_overrun
);

   localparam int BW = $clog2(BURST_LEN) + 1;

   fetch_state_t state, state_nxt;

   logic          req_d;
   logic          req_edge;
   logic [11:0]   line_q;
   logic          buf_sel;
   logic [10:0]   words_q;
   logic [10:0]   word_idx;
   logic [BW-1:0] beat_cnt;
   logic          pend_q;
   logic [11:0]   pend_line;
   logic          pend_buf;
   logic [10:0]   pend_words;
   logic          burst_end;
   logic          beat_wr;
   logic          ovr_evt;
   logic          start_new;
   logic          start_pend;
   logic          unused_bits;

   assign unused_bits = ^{read_line_addr[15:12], vga_mode[0]};

   assign req_edge  = read_line_req & ~req_d;
   // The cycle after the last beat of a burst is spent deciding what comes
   // next, which also places line_done one cycle after the final write.
   assign burst_end = (state == S_DATA) && (beat_cnt == BW'(BURST_LEN));
   assign beat_wr   = (state == S_DATA) && !burst_end && mem_rvalid;
   assign ovr_evt   = req_edge && (state != S_IDLE);

   always_ff @(posedge vga_clk or negedge rst_n_w) begin
      if (!rst_n_w) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      start_new  = 1'b0;
      start_pend = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_edge && !blanking) begin
               state_nxt = S_REQ;
               start_new = 1'b1;
            end
         end
         S_REQ: begin
            if (mem_gnt) state_nxt = S_DATA;
         end
         S_DATA: begin
            if (burst_end) begin
               // A request landing on the decision cycle is taken directly;
               // otherwise a parked request abandons the current line.
               if (req_edge) begin
                  state_nxt = S_REQ;
                  start_new = 1'b1;
               end else if (pend_q) begin
                  state_nxt  = S_REQ;
                  start_pend = 1'b1;
               end else if (word_idx == words_q) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_REQ;
               end
            end
         end
         S_DONE: begin
            if (req_edge) begin
               state_nxt = S_REQ;
               start_new = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge vga_clk or negedge rst_n_w) begin
      if (!rst_n_w) begin
         req_d      <= 1'b0;
         line_q     <= '0;
         buf_sel    <= 1'b0;
         words_q    <= '0;
         word_idx   <= '0;
         beat_cnt   <= '0;
         pend_q     <= 1'b0;
         pend_line  <= '0;
         pend_buf   <= 1'b0;
         pend_words <= '0;
         overrun    <= 1'b0;
      end else begin
         req_d <= read_line_req;

         if (start_new) begin
            line_q   <= read_line_addr[11:0];
            buf_sel  <= read_line_addr[0];
            words_q  <= line_words(vga_mode[1]);
            word_idx <= '0;
         end else if (start_pend) begin
            line_q   <= pend_line;
            buf_sel  <= pend_buf;
            words_q  <= pend_words;
            word_idx <= '0;
         end else if (beat_wr) begin
            word_idx <= word_idx + 11'd1;
         end

         if ((state == S_REQ) && mem_gnt) beat_cnt <= '0;
         else if (beat_wr)                beat_cnt <= beat_cnt + BW'(1);

         // Mid-fetch request: capture it now, since line_q/buf_sel must stay
         // put until the in-flight burst has drained into the old buffer.
         if (ovr_evt) begin
            pend_line  <= read_line_addr[11:0];
            pend_buf   <= read_line_addr[0];
            pend_words <= line_words(vga_mode[1]);
         end
         if (start_new || start_pend) pend_q <= 1'b0;
         else if (ovr_evt)            pend_q <= 1'b1;

         if (ovr_evt)          overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

   assign mem_req   = (state == S_REQ);
   assign mem_addr  = mem_req ? ADDR_W'({line_q, word_idx[9:0]}) : '0;
   assign busy      = (state != S_IDLE);
   assign line_done = (state == S_DONE);

   vga_lb_writer u_lb_writer (
      .vga_clk  (vga_clk),
      .rst_n_w  (rst_n_w),
      .wr_en    (beat_wr),
      .wr_buf   (buf_sel),
      .wr_addr  (word_idx[9:0]),
      .wr_data  (mem_rdata),
      .lb_we_a  (lb_we_a),
      .lb_we_b  (lb_we_b),
      .lb_waddr (lb_waddr),
      .lb_wdata (lb_wdata)
   );

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Bench for vga_line_fetch_ctrl: a memory responder with random beat gaps and
// data, a passive monitor that logs bursts and line-buffer writes, and a
// directed sequence that compares the logs against expectations built from
// line number, mode and burst length.
module tb_vga_line_fetch_ctrl;

   localparam int BL = 16;

   logic        vga_clk;
   logic        rst_n_w;
   logic [1:0]  vga_mode;
   logic        read_line_req;
   logic [15:0] read_line_addr;
   logic        blanking;
   logic        mem_req;
   logic [21:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic        lb_we_a;
   logic        lb_we_b;
   logic [9:0]  lb_waddr;
   logic [15:0] lb_wdata;
   logic        busy;
   logic        line_done;
   logic        overrun;
   logic        clr_overrun;

   int total = 0;
   int bad   = 0;

   vga_line_fetch_ctrl #(.BURST_LEN(BL), .ADDR_W(22)) dut (
      .vga_clk(vga_clk), .rst_n_w(rst_n_w), .vga_mode(vga_mode),
      .read_line_req(read_line_req), .read_line_addr(read_line_addr),
      .blanking(blanking), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .lb_we_a(lb_we_a), .lb_we_b(lb_we_b), .lb_waddr(lb_waddr),
      .lb_wdata(lb_wdata), .busy(busy), .line_done(line_done),
      .overrun(overrun), .clr_overrun(clr_overrun)
   );

   initial begin
      vga_clk = 1'b0;
      forever #5 vga_clk = ~vga_clk;
   end

   // ---------------- memory responder ----------------
   int gnt_delay    = 0;
   int max_gap      = 2;
   int stray_req    = 0;
   int stray_served = 0;
   int exp_data[$];

   initial begin : mem_resp
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge vga_clk);
         mem_rvalid = 1'b0;
         if (!rst_n_w) begin
            mem_gnt = 1'b0;
         end else if (stray_served < stray_req) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'($urandom);
            stray_served++;
         end else if (mem_req) begin
            for (int i = 0; i < gnt_delay; i++) @(negedge vga_clk);
            mem_gnt = 1'b1;
            @(negedge vga_clk);
            mem_gnt = 1'b0;
            for (int b = 0; b < BL; b++) begin
               repeat ($urandom_range(0, max_gap)) @(negedge vga_clk);
               if (!rst_n_w) break;
               mem_rvalid = 1'b1;
               mem_rdata  = 16'($urandom);
               exp_data.push_back(int'(mem_rdata));
               @(negedge vga_clk);
               mem_rvalid = 1'b0;
            end
         end
      end
   end

   // ---------------- passive monitor ----------------
   typedef struct { int b; int a; int d; } wr_t;
   wr_t  wrq[$];
   int   baddr[$];
   int   req_runs[$];
   int   cyc = 0, done_cnt = 0, gap_err = 0, both_cnt = 0, unstable = 0;
   int   lat_err = 0, busy_cycles = 0, last_we = -10, run = 0;
   logic prev_req = 1'b0;
   logic [21:0] prev_addr = '0;

   always begin
      @(posedge vga_clk);
      #1;
      cyc++;
      if (line_done) begin
         done_cnt++;
         if (cyc - last_we != 1) gap_err++;
      end
      if (lb_we_a && lb_we_b) both_cnt++;
      if (lb_we_a || lb_we_b) begin
         wrq.push_back('{(lb_we_b ? 1 : 0), int'(lb_waddr), int'(lb_wdata)});
         last_we = cyc;
         if (!mem_rvalid) lat_err++;
      end
      if (busy) busy_cycles++;
      if (mem_req && !prev_req) baddr.push_back(int'(mem_addr));
      if (mem_req && prev_req && mem_addr != prev_addr) unstable++;
      if (mem_req) run++;
      else if (run > 0) begin
         req_runs.push_back(run);
         run = 0;
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input longint observed, input longint expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic pulse_req(input logic [15:0] addr);
      @(negedge vga_clk);
      read_line_addr = addr;
      read_line_req  = 1'b1;
      @(negedge vga_clk);
      @(negedge vga_clk);
      read_line_req  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 20000 && busy; i++) @(negedge vga_clk);
      chk({tag, "_timeout"}, busy, 0);
      repeat (2) @(negedge vga_clk);
   endtask

   // Expected fetch of one line: sequence of burst addresses and writes.
   // Checks seg_bursts bursts starting at burst index sb and seg_words writes
   // starting at write index sw / data index sd against line l, buffer l[0].
   task automatic chk_segment(input string tag, input int l, input int seg_bursts,
                              input int seg_words, input int sb, input int sw, input int sd);
      int berr, werr;
      berr = 0;
      werr = 0;
      for (int k = 0; k < seg_bursts; k++)
         if (sb + k >= baddr.size() || baddr[sb + k] != (l % 4096) * 1024 + k * BL) berr++;
      for (int k = 0; k < seg_words; k++) begin
         if (sw + k >= wrq.size() || sd + k >= exp_data.size()) werr++;
         else if (wrq[sw + k].b != (l % 2) || wrq[sw + k].a != k ||
                  wrq[sw + k].d != exp_data[sd + k]) werr++;
      end
      chk({tag, "_burst_addr"}, berr, 0);
      chk({tag, "_writes"}, werr, 0);
   endtask

   task automatic run_line(input string tag, input logic [15:0] addr, input logic [1:0] mode,
                           input int gd, input bit flip);
      int sb, sw, sd, sdone, sgap, sboth, sunst, slat, words;
      sb = baddr.size(); sw = wrq.size(); sd = exp_data.size();
      sdone = done_cnt; sgap = gap_err; sboth = both_cnt; sunst = unstable; slat = lat_err;
      gnt_delay = gd;
      vga_mode  = mode;
      words = mode[1] ? 1024 : 640;
      pulse_req(addr);
      if (flip) begin
         repeat (60) @(negedge vga_clk);
         vga_mode = ~mode;
      end
      wait_idle(tag);
      chk({tag, "_nbursts"}, baddr.size() - sb, words / BL);
      chk({tag, "_nwrites"}, wrq.size() - sw, words);
      chk_segment(tag, int'(addr[11:0]), words / BL, words, sb, sw, sd);
      chk({tag, "_line_done"}, done_cnt - sdone, 1);
      chk({tag, "_done_timing"}, gap_err - sgap, 0);
      chk({tag, "_both_we"}, both_cnt - sboth, 0);
      chk({tag, "_addr_stable"}, unstable - sunst, 0);
      chk({tag, "_wr_latency"}, lat_err - slat, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      int sb, sw, sd, sdone, sbusy, sruns, rerr, maxa;
      rst_n_w        = 1'b0;
      vga_mode       = 2'b00;
      read_line_req  = 1'b0;
      read_line_addr = '0;
      blanking       = 1'b0;
      clr_overrun    = 1'b0;
      repeat (3) @(negedge vga_clk);
      chk("reset_outputs", {mem_req, mem_addr, lb_we_a, lb_we_b, lb_waddr, lb_wdata,
                            busy, line_done, overrun}, 0);
      rst_n_w = 1'b1;
      repeat (2) @(negedge vga_clk);

      // 640-word line 0x25 into buffer B.
      run_line("line25", 16'h0025, 2'b00, 0, 1'b0);
      chk("line25_first_addr", baddr[0], 'h009400);

      // 1024-word line 0xFFE into buffer A.
      sw = wrq.size();
      run_line("lineffe", 16'h0FFE, 2'b10, $urandom_range(0, 3), 1'b0);
      chk("lineffe_last_addr", baddr[baddr.size() - 1], 'h3FFBF0);
      maxa = 0;
      for (int k = sw; k < wrq.size(); k++) if (wrq[k].a > maxa) maxa = wrq[k].a;
      chk("lineffe_max_waddr", maxa, 1023);

      // Grant held off 7 cycles: every request lasts 8 cycles.
      sruns = req_runs.size();
      run_line("gnt7", 16'h0102, 2'b00, 7, 1'b0);
      rerr = 0;
      for (int k = sruns; k < req_runs.size(); k++) if (req_runs[k] != 8) rerr++;
      chk("gnt7_req_len", rerr, 0);
      chk("gnt7_nruns", req_runs.size() - sruns, 40);

      // Random lines, mode flipped mid-line (must not change the fetch).
      for (int n = 0; n < 2; n++)
         run_line("rand", 16'($urandom), 2'($urandom), $urandom_range(0, 3), 1'b1);

      // Overrun: new request during burst 3 of line 0x10.
      sb = baddr.size(); sw = wrq.size(); sd = exp_data.size(); sdone = done_cnt;
      gnt_delay = 1;
      vga_mode  = 2'b00;
      pulse_req(16'h0010);
      for (int i = 0; i < 5000 && wrq.size() < sw + 36; i++) @(negedge vga_clk);
      chk("ovr_reach_burst3", baddr.size() - sb, 3);
      pulse_req(16'h0011);
      wait_idle("ovr");
      chk("ovr_nbursts", baddr.size() - sb, 3 + 40);
      chk("ovr_nwrites", wrq.size() - sw, 48 + 640);
      chk_segment("ovr_old", 'h10, 3, 48, sb, sw, sd);
      chk_segment("ovr_new", 'h11, 40, 640, sb + 3, sw + 48, sd + 48);
      chk("ovr_restart_addr", baddr[sb + 3], 'h004400);
      chk("ovr_line_done", done_cnt - sdone, 1);
      chk("ovr_sticky", overrun, 1);
      repeat (5) @(negedge vga_clk);
      chk("ovr_still_set", overrun, 1);
      clr_overrun = 1'b1;
      @(negedge vga_clk);
      clr_overrun = 1'b0;
      chk("ovr_cleared", overrun, 0);

      // Blanking inhibits fetch start.
      sb = baddr.size(); sbusy = busy_cycles;
      blanking = 1'b1;
      pulse_req(16'h0033);
      repeat (20) @(negedge vga_clk);
      chk("blank_no_req", baddr.size() - sb, 0);
      chk("blank_no_busy", busy_cycles - sbusy, 0);
      blanking = 1'b0;

      // Reset at word 300, then stray beats after release.
      sw = wrq.size();
      gnt_delay = 0;
      pulse_req(16'h0040);
      for (int i = 0; i < 5000 && wrq.size() < sw + 300; i++) @(negedge vga_clk);
      chk("rst_reached_300", wrq.size() - sw >= 300, 1);
      rst_n_w = 1'b0;
      #1;
      chk("rst_outputs_now", {mem_req, mem_addr, lb_we_a, lb_we_b, lb_waddr, lb_wdata,
                              busy, line_done, overrun}, 0);
      @(negedge vga_clk);
      chk("rst_outputs_next", {mem_req, mem_addr, lb_we_a, lb_we_b, lb_waddr, lb_wdata,
                               busy, line_done, overrun}, 0);
      repeat (2) @(negedge vga_clk);
      rst_n_w = 1'b1;
      sb = baddr.size(); sw = wrq.size(); sbusy = busy_cycles;
      stray_req = stray_req + 20;
      repeat (30) @(negedge vga_clk);
      chk("stray_served", stray_served, stray_req);
      chk("stray_no_writes", wrq.size() - sw, 0);
      chk("stray_no_req", baddr.size() - sb, 0);
      chk("stray_no_busy", busy_cycles - sbusy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_line_fetch_ctrl.md
# vga_line_fetch_ctrl

Line-prefetch scheduler between the VGA timing driver and the frame-memory burst port. On each rising edge of the driver's line request it fetches the next scan line from frame memory in fixed-length bursts. It writes that line into the idle half of the A/B ping-pong line buffer, so the pixel side reads the other half undisturbed. It also reports busy state and sticky overrun status to the system.

## Interface
Parameters:
- BURST_LEN, 16: words per memory burst; power of two, divides 640 and 1024.
- ADDR_W, 22: memory word-address width; address = {line[11:0], word[9:0]}.

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge.
- rst_n_w  in  1  reset, asynchronous, active-low.
- vga_mode  in  2  bit1=1 selects 1024-word lines, otherwise 640.
- read_line_req  in  1  level from driver; rising edge starts a fetch.
- read_line_addr  in  16  line to fetch; bits [11:0] used; bit0 selects buffer (0=A, 1=B).
- blanking  in  1  vertical blanking; inhibits new fetch starts.
- mem_req  out  1  burst request; held until granted.
- mem_addr  out  ADDR_W  burst start word address; stable while mem_req=1.
- mem_gnt  in  1  one-cycle grant.
- mem_rvalid  in  1  read word valid.
- mem_rdata  in  16  read word.
- lb_we_a  out  1  write strobe, buffer A.
- lb_we_b  out  1  write strobe, buffer B.
- lb_waddr  out  10  line-buffer word address.
- lb_wdata  out  16  line-buffer data.
- busy  out  1  fetch in progress.
- line_done  out  1  one-cycle pulse when the last word of a line is written.
- overrun  out  1  sticky; new request arrived before the previous line completed.
- clr_overrun  in  1  synchronous clear of overrun.

## Operation
- FSM states are IDLE, REQ, DATA and DONE.
- IDLE:
  - A rising edge of read_line_req with blanking=0 latches line = read_line_addr[11:0], buf = read_line_addr[0], and words = (vga_mode[1] ? 1024 : 640).
  - It clears word_idx and goes to REQ.
  - An edge while blanking=1 is ignored.
- REQ: mem_req=1 and mem_addr = {line, word_idx}. When mem_gnt=1, go to DATA and clear beat_cnt.
- DATA:
  - Each mem_rvalid writes mem_rdata to the selected buffer at word_idx, then increments word_idx and beat_cnt.
  - When beat_cnt reaches BURST_LEN: go to DONE if word_idx == words, otherwise go to REQ.
- DONE: pulse line_done, then return to IDLE.
- Overrun: a rising edge while the FSM is not IDLE sets overrun and marks a pending restart.
  - The current burst drains fully, with writes still performed.
  - On burst end the FSM restarts in REQ with the newly latched line, buf and words, and word_idx=0.
  - No line_done is issued for the aborted line.
- mem_rvalid outside DATA is ignored.
- vga_mode is sampled only at fetch start; a mid-line mode change has no effect on the current fetch.
- clr_overrun is ignored when it coincides with a setting event; set wins.

## Timing
- Reset values: all outputs 0; state IDLE.
- Edge detect uses one register. An edge sampled at cycle t gives mem_req=1 at t+1.
- mem_req deasserts in the cycle after mem_gnt is sampled high. The next mem_req is no earlier than 1 cycle after the last beat of the previous burst.
- Line-buffer writes are registered: rvalid at cycle t gives lb_we_x, lb_waddr and lb_wdata at t+1.
- Exactly one of lb_we_a and lb_we_b is high per write.
- line_done is high in the cycle after the final lb_we.
- busy = (state != IDLE).
- Width and wrap rules:
  - word_idx is 11 bits, so 1024 is representable.
  - lb_waddr = word_idx[9:0].
  - Line address uses bits [11:0] only, so the line counter wraps at 4096.
- Reset asserted mid-burst aborts immediately. Memory beats still in flight after reset release are ignored, because the FSM is in IDLE.

## Structure
- Package vga_pkg holds:
  - the FSM state enum;
  - the constants LINE_WORDS_640=640 and LINE_WORDS_1024=1024;
  - the default BURST_LEN.
- One sub-module, vga_lb_writer: registered line-buffer write port (buffer select, address and data pipeline register). The FSM and counters stay in the top module.

## Test plan
- Mode 00, request edge with read_line_addr=0x0025:
  - 40 bursts at mem_addr 0x009400 + 16k, for k = 0..39;
  - only lb_we_b pulses, 640 writes at addresses 0..639;
  - one line_done.
- vga_mode=2'b10, read_line_addr=0x0FFE: 64 bursts; only lb_we_a; last mem_addr=0x3FFBF0; lb_waddr reaches 1023.
- Grant delayed 7 cycles: mem_addr held constant, mem_req high for 8 cycles; data latency is exactly 1 cycle from rvalid to lb_we.
- Second edge (addr 0x0011) during burst 3 of line 0x0010:
  - the burst completes;
  - overrun=1;
  - the restart fetches from 0x004400;
  - overrun remains set until clr_overrun.
- Edge with blanking=1: no mem_req; busy stays 0.
- Reset at word 300: all outputs 0 next cycle; 20 stray rvalids after release produce no writes.
